// File: rtl/arm_ldm_sequencer_if.sv
// Bus between the decode stage and the LDM/STM sequencer: the decoded
// block-transfer request going in, and the transfer/writeback micro-ops coming out.
interface arm_ldm_sequencer_if #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(NREGS);

  logic              start;
  logic [NREGS-1:0]  reglist;
  logic              load;
  logic              up;
  logic              pre;
  logic              wb;
  logic [IDX_W-1:0]  base_reg;
  logic [ADDR_W-1:0] base;
  logic              hold;
  logic              flush;

  logic              busy;
  logic              stallF;
  logic              uop_valid;
  logic [IDX_W-1:0]  uop_reg;
  logic [ADDR_W-1:0] uop_addr;
  logic              uop_load;
  logic              uop_last;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_value;
  logic              done;

  modport master (
    output start, reglist, load, up, pre, wb, base_reg, base, hold, flush,
    input  busy, stallF, uop_valid, uop_reg, uop_addr, uop_load, uop_last,
           wb_valid, wb_value, done
  );

  modport slave (
    input  start, reglist, load, up, pre, wb, base_reg, base, hold, flush,
    output busy, stallF, uop_valid, uop_reg, uop_addr, uop_load, uop_last,
           wb_valid, wb_value, done
  );
endinterface

// File: rtl/arm_ldm_sequencer.sv
// Expands one decoded LDM/STM into per-register transfer micro-ops (ascending
// index, ascending address), followed by an optional base-writeback micro-op.
module arm_ldm_sequencer #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input logic                clk,
  input logic                rst,
  arm_ldm_sequencer_if.slave bus_io
);
  localparam int IDX_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(NREGS + 1);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] lowestIdx(input logic [NREGS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NREGS - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic              wbEn_q, wbEn_d;
  logic              busy_q, busy_d;
  logic              uopValid_q, uopValid_d;
  logic [IDX_W-1:0]  uopReg_q, uopReg_d;
  logic [ADDR_W-1:0] uopAddr_q, uopAddr_d;
  logic              uopLoad_q, uopLoad_d;
  logic              uopLast_q, uopLast_d;
  logic              wbValid_q, wbValid_d;
  logic [ADDR_W-1:0] wbValue_q, wbValue_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  n;
  logic [ADDR_W-1:0] nStep;
  logic [ADDR_W-1:0] lowAddr;
  logic [ADDR_W-1:0] newBase;
  logic [IDX_W-1:0]  firstIdx;
  logic [NREGS-1:0]  restList;
  logic [IDX_W-1:0]  nextIdx;
  logic [NREGS-1:0]  nextPend;
  logic              accept;
  logic              lastBusy;

  // Request-side arithmetic; all address math wraps modulo 2^ADDR_W.
  always_comb begin
    n        = popcount(bus_io.reglist);
    nStep    = ADDR_W'(n) * ADDR_W'(STEP);
    case ({bus_io.up, bus_io.pre})
      2'b11:   lowAddr = bus_io.base + ADDR_W'(STEP);
      2'b10:   lowAddr = bus_io.base;
      2'b01:   lowAddr = bus_io.base - nStep;
      default: lowAddr = bus_io.base - nStep + ADDR_W'(STEP);
    endcase
    newBase  = bus_io.up ? bus_io.base + nStep : bus_io.base - nStep;
    firstIdx = lowestIdx(bus_io.reglist);
    restList = bus_io.reglist & ~(NREGS'(1) << firstIdx);
    nextIdx  = lowestIdx(pend_q);
    nextPend = pend_q & ~(NREGS'(1) << nextIdx);
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    wbEn_d     = wbEn_q;
    uopValid_d = uopValid_q;
    uopReg_d   = uopReg_q;
    uopAddr_d  = uopAddr_q;
    uopLoad_d  = uopLoad_q;
    uopLast_d  = uopLast_q;
    wbValid_d  = wbValid_q;
    wbValue_d  = wbValue_q;
    done_d     = 1'b0;
    if (bus_io.flush) begin
      state_d    = IDLE;
      uopValid_d = 1'b0;
      uopLast_d  = 1'b0;
      wbValid_d  = 1'b0;
    end else if (!bus_io.hold) begin
      case (state_q)
        IDLE: begin
          uopValid_d = 1'b0;
          uopLast_d  = 1'b0;
          wbValid_d  = 1'b0;
          if (bus_io.start) begin
            uopLoad_d = bus_io.load;
            wbValue_d = newBase;
            // A base register that is also loaded keeps the loaded value.
            wbEn_d    = bus_io.wb & ~(bus_io.load & bus_io.reglist[bus_io.base_reg]);
            if (n != '0) begin
              state_d    = XFER;
              uopValid_d = 1'b1;
              uopReg_d   = firstIdx;
              uopAddr_d  = lowAddr;
              uopLast_d  = (restList == '0);
              pend_d     = restList;
            end else if (bus_io.wb) begin
              state_d   = WB;
              wbValid_d = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        XFER: begin
          if (uopLast_q) begin
            uopValid_d = 1'b0;
            uopLast_d  = 1'b0;
            if (wbEn_q) begin
              state_d   = WB;
              wbValid_d = 1'b1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            uopReg_d  = nextIdx;
            uopAddr_d = uopAddr_q + ADDR_W'(STEP);
            pend_d    = nextPend;
            uopLast_d = (nextPend == '0);
          end
        end
        WB: begin
          state_d   = IDLE;
          wbValid_d = 1'b0;
          done_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      wbEn_q     <= 1'b0;
      busy_q     <= 1'b0;
      uopValid_q <= 1'b0;
      uopReg_q   <= '0;
      uopAddr_q  <= '0;
      uopLoad_q  <= 1'b0;
      uopLast_q  <= 1'b0;
      wbValid_q  <= 1'b0;
      wbValue_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      wbEn_q     <= wbEn_d;
      busy_q     <= busy_d;
      uopValid_q <= uopValid_d;
      uopReg_q   <= uopReg_d;
      uopAddr_q  <= uopAddr_d;
      uopLoad_q  <= uopLoad_d;
      uopLast_q  <= uopLast_d;
      wbValid_q  <= wbValid_d;
      wbValue_q  <= wbValue_d;
      done_q     <= done_d;
    end
  end

  // The fetch stall drops one cycle early so F/D restarts in step with the last micro-op.
  always_comb begin
    accept   = (state_q == IDLE) && bus_io.start && !bus_io.hold && !bus_io.flush;
    lastBusy = ((state_q == XFER) && uopLast_q && !wbEn_q) || (state_q == WB);
    bus_io.stallF = !rst && ((accept && ((n != '0) || bus_io.wb)) ||
                             ((state_q != IDLE) && !lastBusy));
  end

  assign bus_io.busy      = busy_q;
  assign bus_io.uop_valid = uopValid_q;
  assign bus_io.uop_reg   = uopReg_q;
  assign bus_io.uop_addr  = uopAddr_q;
  assign bus_io.uop_load  = uopLoad_q;
  assign bus_io.uop_last  = uopLast_q;
  assign bus_io.wb_valid  = wbValid_q;
  assign bus_io.wb_value  = wbValue_q;
  assign bus_io.done      = done_q;
endmodule

// File: doc/arm_ldm_sequencer.md
ARM_LDM_SEQUENCER -- requirements
Module: arm_ldm_sequencer

Parameters
REQ-001 SHALL have parameter NREGS, default 16: register-list width and register-file size, power of two, 2..32.
REQ-002 SHALL have parameter ADDR_W, default 32: address/base width.
REQ-003 SHALL have parameter STEP, default 4: byte increment per transferred register.

Interface
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  LDM/STM decoded in D; sampled only in IDLE.
REQ-007 reglist  in  NREGS  register list; bit i selects register i.
REQ-008 load  in  1  1 = LDM, 0 = STM.
REQ-009 up  in  1  U bit; 1 = increment, 0 = decrement.
REQ-010 pre  in  1  P bit; 1 = before, 0 = after.
REQ-011 wb  in  1  W bit; base writeback requested.
REQ-012 base_reg  in  log2(NREGS)  base register index.
REQ-013 base  in  ADDR_W  base register value.
REQ-014 hold  in  1  downstream stall; freezes the sequencer.
REQ-015 flush  in  1  pipeline flush; aborts the sequence.
REQ-016 busy  out  1  state != IDLE.
REQ-017 stallF  out  1  stall request for F/D.
REQ-018 uop_valid  out  1  transfer micro-op valid.
REQ-019 uop_reg  out  log2(NREGS)  register index for this transfer.
REQ-020 uop_addr  out  ADDR_W  memory address for this transfer.
REQ-021 uop_load  out  1  captured load bit.
REQ-022 uop_last  out  1  final transfer of the list.
REQ-023 wb_valid  out  1  base writeback micro-op valid.
REQ-024 wb_value  out  ADDR_W  new base value.
REQ-025 done  out  1  one-cycle pulse when the sequence completes.

Function
REQ-026 SHALL implement states IDLE, XFER, WB; all outputs registered except stallF.
REQ-027 In IDLE with start=1, SHALL capture all inputs; n = popcount(reglist).
REQ-028 n>0: next state XFER; n=0 and wb=1: next state WB; n=0 and wb=0: stay IDLE, done=1 next cycle.
REQ-029 Lowest address: up&pre: base+STEP; up&~pre: base; ~up&pre: base-n*STEP; ~up&~pre: base-n*STEP+STEP.
REQ-030 Transfers SHALL issue in ascending register index at ascending addresses starting at the lowest address, +STEP per transfer, one per non-held cycle.
REQ-031 First uop_valid SHALL appear the cycle after start (latency 1).
REQ-032 wb_value SHALL be base+n*STEP if up, else base-n*STEP.
REQ-033 All address arithmetic SHALL be modulo 2^ADDR_W.
REQ-034 After the uop_last cycle: next state WB if wb, else IDLE with done=1.
REQ-035 WB SHALL last one cycle with wb_valid=1, then IDLE with done=1.
REQ-036 If load=1 and reglist[base_reg]=1, SHALL skip WB; loaded value wins.
REQ-037 hold=1 SHALL freeze state and all registered outputs; done is not pulsed while hold=1.
REQ-038 flush=1 SHALL force IDLE at the next edge with no writeback and no done; flush overrides hold and start.
REQ-039 start while busy SHALL be ignored.
REQ-040 stallF SHALL be 1 in the cycle start is accepted with n>0 or wb=1, and in every busy cycle except the last (the uop_last cycle when no WB follows, or the WB cycle).

Reset
REQ-041 On rst=1, SHALL enter IDLE immediately (asynchronously), including mid-sequence; no writeback or done is produced for the aborted sequence.
REQ-042 While in reset, all outputs SHALL be 0: busy, stallF, uop_valid, uop_reg, uop_addr, uop_load, uop_last, wb_valid, wb_value, done.

Verification
REQ-043 LDMIA, base=0x100, reglist=0x000B, wb=1 -> r0@0x100, r1@0x104, r3@0x108 (uop_last on r3), then wb_value=0x10C, then done.
REQ-044 STMDB, base=0x200, reglist=0xC000, wb=1 -> r14@0x1F8, r15@0x1FC, wb_value=0x1F8; stallF low only in the WB cycle.
REQ-045 LDMIB, base=0x10, reglist=0x0021, base_reg=5, wb=1 -> r0@0x14, r5@0x18; no wb_valid; done after r5.
REQ-046 hold=1 for 3 cycles during the 2nd transfer -> outputs frozen, resume at same uop; flush during the next transfer -> IDLE, no wb_valid/done.
REQ-047 Empty list: wb=0 -> busy never high, done next cycle; wb=1 -> WB only, wb_value=base.
REQ-048 Wrap and reset: base=0xFFFFFFFC, LDMIA of r0,r1 -> addresses 0xFFFFFFFC, 0x00000000; rst mid-sequence -> IDLE immediately, all outputs 0.
